// File: rtl/plusminus_pkg.sv
// Shared types and seven-segment patterns for the plus/minus BCD counter.
package plusminus_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low, bit order a..g = bit0..bit6.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal codes blank.
module bcd_to_7seg
  import plusminus_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/plusminus_counter.sv
// Up/down NDIG-digit BCD counter fed by toggle-style one-shot outputs,
// with registered active-low seven-segment drive and overflow/underflow pulses.
module plusminus_counter
  import plusminus_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int WRAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              plus_tgl,
  input  logic              minus_tgl,
  input  logic              clr_tgl,
  output logic [4*NDIG-1:0] count_bcd,
  output logic [7*NDIG-1:0] seg,
  output logic              ovf,
  output logic              unf
);

  logic              r_p_prev, r_m_prev, r_c_prev;
  logic [4*NDIG-1:0] r_count;
  logic [7*NDIG-1:0] r_seg;
  logic              r_ovf, r_unf;

  logic              w_inc, w_dec, w_clr;
  logic [NDIG-1:0]   w_is9, w_is0;
  logic [NDIG:0]     w_carry, w_borrow;
  logic [4*NDIG-1:0] w_inc_val, w_dec_val, w_next;
  logic [7*NDIG-1:0] w_seg_dec;
  logic              w_at_max, w_at_zero;
  logic              w_ovf, w_unf;

  assign w_inc = plus_tgl  ^ r_p_prev;
  assign w_dec = minus_tgl ^ r_m_prev;
  assign w_clr = clr_tgl   ^ r_c_prev;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    bcd_t w_d;
    assign w_d       = r_count[4*gi +: 4];
    assign w_is9[gi] = (w_d == 4'd9);
    assign w_is0[gi] = (w_d == 4'd0);
    assign w_inc_val[4*gi +: 4] = !w_carry[gi]  ? w_d : (w_is9[gi] ? 4'd0 : w_d + 4'd1);
    assign w_dec_val[4*gi +: 4] = !w_borrow[gi] ? w_d : (w_is0[gi] ? 4'd9 : w_d - 4'd1);

    bcd_to_7seg u_dec (
      .i_bcd (w_d),
      .o_seg (w_seg_dec[7*gi +: 7])
    );
  end

  // Carry into digit i is "all lower digits are 9"; computed as a flat AND
  // over a mask rather than a rippled chain so no signal feeds back into itself.
  for (genvar gi = 0; gi <= NDIG; gi++) begin : g_chain
    localparam logic [NDIG-1:0] LOWER = NDIG'((1 << gi) - 1);
    assign w_carry[gi]  = &(w_is9 | ~LOWER);
    assign w_borrow[gi] = &(w_is0 | ~LOWER);
  end

  assign w_at_max  = w_carry[NDIG];
  assign w_at_zero = w_borrow[NDIG];

  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (w_clr) begin
      w_next = '0;
    end else if (w_inc && !w_dec) begin
      w_ovf = w_at_max;
      if (!w_at_max || WRAP != 0) w_next = w_inc_val;
    end else if (w_dec && !w_inc) begin
      w_unf = w_at_zero;
      if (!w_at_zero || WRAP != 0) w_next = w_dec_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_prev <= 1'b0;
      r_m_prev <= 1'b0;
      r_c_prev <= 1'b0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_seg    <= {NDIG{SEG_0}};
    end else begin
      r_p_prev <= plus_tgl;
      r_m_prev <= minus_tgl;
      r_c_prev <= clr_tgl;
      r_count  <= w_next;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_seg    <= w_seg_dec;
    end
  end

  assign count_bcd = r_count;
  assign seg       = r_seg;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_plusminus_counter.sv
// Scoreboard bench: wrapping and saturating counters driven in parallel against an integer model.
module tb_plusminus_counter;

  localparam int NDIG = 2;
  localparam int MAXV = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_in = 1'b0, m_in = 1'b0, c_in = 1'b0;
  logic [7:0]  cnt_w, cnt_s;
  logic [13:0] seg_w, seg_s;
  logic        ovf_w, unf_w, ovf_s, unf_s;

  always #5 clk = ~clk;

  plusminus_counter #(.NDIG(NDIG), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .plus_tgl(p_in), .minus_tgl(m_in), .clr_tgl(c_in),
    .count_bcd(cnt_w), .seg(seg_w), .ovf(ovf_w), .unf(unf_w)
  );

  plusminus_counter #(.NDIG(NDIG), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .plus_tgl(p_in), .minus_tgl(m_in), .clr_tgl(c_in),
    .count_bcd(cnt_s), .seg(seg_s), .ovf(ovf_s), .unf(unf_s)
  );

  typedef struct {
    logic [7:0]  cw, cs;
    logic [13:0] sw, ss;
    bit          ow, uw, os, us;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   mw = 0, ms = 0;
  bit   mp = 0, mm = 0, mc = 0;
  logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] segs(int v);
    return {PAT[v / 10], PAT[v % 10]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic upd(input bit inc, input bit dec, input bit clr, input bit wrap,
                     input int vin, output int vout, output bit o, output bit u);
    vout = vin; o = 0; u = 0;
    if (clr) vout = 0;
    else if (inc && !dec) begin
      if (vin == MAXV) begin o = 1; vout = wrap ? 0 : MAXV; end
      else vout = vin + 1;
    end else if (dec && !inc) begin
      if (vin == 0) begin u = 1; vout = wrap ? MAXV : 0; end
      else vout = vin - 1;
    end
  endtask

  task automatic step(input bit tp, input bit tm, input bit tc);
    exp_t e;
    bit inc, dec, clr;
    int nw, ns;
    @(negedge clk);
    p_in = p_in ^ tp;
    m_in = m_in ^ tm;
    c_in = c_in ^ tc;
    inc = (p_in != mp); mp = p_in;
    dec = (m_in != mm); mm = m_in;
    clr = (c_in != mc); mc = c_in;
    e.sw = segs(mw);
    e.ss = segs(ms);
    upd(inc, dec, clr, 1'b1, mw, nw, e.ow, e.uw);
    upd(inc, dec, clr, 1'b0, ms, ns, e.os, e.us);
    mw = nw; ms = ns;
    e.cw = bcd(mw);
    e.cs = bcd(ms);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q.size() != 0) begin
      me = q.pop_front();
      chk("count_wrap", 32'(cnt_w), 32'(me.cw));
      chk("count_sat",  32'(cnt_s), 32'(me.cs));
      chk("seg_wrap",   32'(seg_w), 32'(me.sw));
      chk("seg_sat",    32'(seg_s), 32'(me.ss));
      chk("flags_wrap", 32'({ovf_w, unf_w}), 32'({me.ow, me.uw}));
      chk("flags_sat",  32'({ovf_s, unf_s}), 32'({me.os, me.us}));
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", 32'({cnt_w, cnt_s}), 32'({bcd(0), bcd(0)}));
    chk("rst_seg",   32'(seg_w), 32'(segs(0)));
    chk("rst_flags", 32'({ovf_w, unf_w, ovf_s, unf_s}), 32'(0));
    rst = 1'b0;

    // Twelve spaced increments
    repeat (12) begin step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); end
    step(0, 0, 0);

    // Limits: both counters reach 99, then overflow/underflow, then underflow at 0
    step(0, 0, 1);
    repeat (99) step(1, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0);
    step(0, 0, 1); step(0, 1, 0); step(0, 0, 0);

    // Cancel and clear priority
    step(0, 0, 1);
    repeat (5) step(1, 0, 0);
    step(1, 1, 0); step(0, 0, 0);
    step(1, 0, 1); step(0, 0, 0);

    // Carry 09 -> 13 with back-to-back toggles
    step(0, 0, 1);
    repeat (9) step(1, 0, 0);
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    step(0, 0, 0);

    // Asynchronous reset at 37 with plus held high through release
    step(0, 0, 1);
    repeat (37) step(1, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_count", 32'(cnt_w), 32'(bcd(mw)));
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'({cnt_w, cnt_s}), 32'(0));
    chk("async_rst_seg",   32'({seg_w, seg_s}), 32'({segs(0), segs(0)}));
    chk("async_rst_flags", 32'({ovf_w, unf_w, ovf_s, unf_s}), 32'(0));
    p_in = 1'b1; m_in = 1'b0; c_in = 1'b0;
    mp = 0; mm = 0; mc = 0;
    mw = 0; ms = 0;
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Randomised traffic
    repeat (400)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
